seq_detect_ctrl: RTL

Sequencing controller for the serial sequence-detector datapath. It takes parallel words over a valid/ready handshake and serializes them MSB-first onto a one-bit-per-cycle detector stream. It matches the stream against a runtime-programmable pattern of up to PAT_MAX bits, with overlapping or non-overlapping detection, and keeps a saturating match count. It sits between the word-level producer and the serial detect path, replacing per-pattern hard-coded FSMs with one configurable block.

---
 rtl/seq_detect_pkg.sv | 13 +
 rtl/seq_match_core.sv | 96 +++++++++
 rtl/seq_detect_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and default sizing for the sequence-detector controller slice.
package seq_detect_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int WORD_W_DEF  = 8;
  localparam int PAT_MAX_DEF = 8;
  localparam int CNT_W_DEF   = 8;

endpackage

// File: rtl/seq_match_core.sv
// Programmable pattern matcher: history/fill tracking, latched configuration,
// masked compare and a saturating match counter.
module seq_match_core
  import seq_detect_pkg::*;
#(
  parameter int PAT_MAX = PAT_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               cfg_en,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               bit_in,
  input  logic               bit_en,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [PAT_MAX-1:0] pat_r;
  logic [PAT_MAX-1:0] hist_r;
  logic [PAT_MAX-1:0] hist_nxt_s;
  logic [PAT_MAX-1:0] mask_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   fill_r;
  logic [LEN_W-1:0]   fill_inc_s;
  logic [LEN_W-1:0]   len_clamp_s;
  logic [LEN_W:0]     fill_p1_s;
  logic               ovl_r;
  logic               hit_s;
  logic               match_r;
  logic [CNT_W-1:0]   cnt_r;

  // Next history, length mask, hit decision and clamped inputs.
  always_comb begin
    hist_nxt_s = {hist_r[PAT_MAX-2:0], bit_in};
    fill_p1_s  = {1'b0, fill_r} + {{LEN_W{1'b0}}, 1'b1};
    for (int i = 0; i < PAT_MAX; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    hit_s = bit_en && (len_r != {LEN_W{1'b0}}) && (fill_p1_s >= {1'b0, len_r}) &&
            ((hist_nxt_s & mask_s) == (pat_r & mask_s));
    if (fill_p1_s > (LEN_W + 1)'(PAT_MAX)) begin
      fill_inc_s = LEN_W'(PAT_MAX);
    end else begin
      fill_inc_s = fill_p1_s[LEN_W-1:0];
    end
    if (cfg_len > LEN_W'(PAT_MAX)) begin
      len_clamp_s = LEN_W'(PAT_MAX);
    end else begin
      len_clamp_s = cfg_len;
    end
  end

  // Configuration, history/fill and counter state; cnt_clr beats a same-edge hit.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pat_r   <= {PAT_MAX{1'b0}};
      len_r   <= {LEN_W{1'b0}};
      ovl_r   <= 1'b1;
      hist_r  <= {PAT_MAX{1'b0}};
      fill_r  <= {LEN_W{1'b0}};
      match_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      match_r <= hit_s;
      if (cfg_en) begin
        pat_r  <= cfg_pattern;
        len_r  <= len_clamp_s;
        ovl_r  <= cfg_overlap;
        hist_r <= {PAT_MAX{1'b0}};
        fill_r <= {LEN_W{1'b0}};
      end else if (bit_en) begin
        hist_r <= hist_nxt_s;
        fill_r <= (hit_s && !ovl_r) ? {LEN_W{1'b0}} : fill_inc_s;
      end else begin
        hist_r <= hist_r;
        fill_r <= fill_r;
      end
      if (cnt_clr) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (hit_s && (cnt_r != {CNT_W{1'b1}})) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign match     = match_r;
  assign match_cnt = cnt_r;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Word-to-serial sequencing controller feeding the programmable pattern matcher.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter  int WORD_W  = WORD_W_DEF,
  parameter  int PAT_MAX = PAT_MAX_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int LEN_W   = $clog2(PAT_MAX + 1)
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               cfg_we,
  input  logic [PAT_MAX-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  input  logic               in_valid,
  input  logic [WORD_W-1:0]  in_data,
  output logic               in_ready,
  output logic               bit_out,
  output logic               bit_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [IDX_W-1:0] IDX_PREV = IDX_W'(WORD_W - 2);

  state_t            state_r;
  logic [WORD_W-1:0] shreg_r;
  logic [IDX_W-1:0]  bit_idx_r;
  logic              bit_out_r;
  logic              bit_valid_r;
  logic              ready_r;
  logic              cfg_en_s;

  // Handshake/serializer FSM; ready_r tracks the next-cycle in_ready so it stays registered.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_r     <= S_IDLE;
      shreg_r     <= {WORD_W{1'b0}};
      bit_idx_r   <= {IDX_W{1'b0}};
      bit_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            shreg_r     <= in_data;
            bit_out_r   <= in_data[WORD_W-1];
            bit_valid_r <= 1'b1;
            bit_idx_r   <= {IDX_W{1'b0}};
            ready_r     <= 1'b0;
            state_r     <= S_SHIFT;
          end else begin
            bit_out_r   <= 1'b0;
            bit_valid_r <= 1'b0;
            ready_r     <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (bit_idx_r == IDX_LAST) begin
            if (in_valid) begin
              shreg_r     <= in_data;
              bit_out_r   <= in_data[WORD_W-1];
              bit_valid_r <= 1'b1;
              bit_idx_r   <= {IDX_W{1'b0}};
              ready_r     <= 1'b0;
            end else begin
              bit_out_r   <= 1'b0;
              bit_valid_r <= 1'b0;
              ready_r     <= 1'b1;
              state_r     <= S_IDLE;
            end
          end else begin
            shreg_r     <= {shreg_r[WORD_W-2:0], 1'b0};
            bit_out_r   <= shreg_r[WORD_W-2];
            bit_valid_r <= 1'b1;
            bit_idx_r   <= bit_idx_r + IDX_W'(1);
            ready_r     <= (bit_idx_r == IDX_PREV);
          end
        end
        default: begin
          state_r     <= S_IDLE;
          bit_out_r   <= 1'b0;
          bit_valid_r <= 1'b0;
          ready_r     <= 1'b1;
        end
      endcase
    end
  end

  assign cfg_en_s  = cfg_we && (state_r == S_IDLE);
  assign in_ready  = clr_n && ready_r;
  assign bit_out   = bit_out_r;
  assign bit_valid = bit_valid_r;
  assign busy      = (state_r == S_SHIFT);

  seq_match_core #(
    .PAT_MAX(PAT_MAX),
    .CNT_W  (CNT_W),
    .LEN_W  (LEN_W)
  ) u_match (
    .clk        (clk),
    .clr_n      (clr_n),
    .cfg_en     (cfg_en_s),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr    (cnt_clr),
    .bit_in     (bit_out_r),
    .bit_en     (bit_valid_r),
    .match      (match),
    .match_cnt  (match_cnt)
  );

endmodule
